// File: rtl/l1_l2_req_arbiter.sv
// l1_l2_req_arbiter
// Shares one single-port L2 front end between the Icache refill port and
// the Dcache miss/uncached port. Only one transaction is outstanding at a time.
// addrOK, dataOK and read data are routed back to the granted requester only.
//
// Handshake: a requester raises *_req with stable fields and holds them until
// its addrOK pulse. The arbiter samples requests only in IDLE and latches the
// winner's fields. It presents them on the L2 port the following cycle (ADDR)
// until l2cache_arb_addrOK. It then waits in DATA for l2cache_arb_dataOK.
// Both L2 acknowledges are forwarded to the owner combinationally in the cycle
// they arrive. If addrOK and dataOK arrive together, the transaction completes
// in that ADDR cycle.
//
// Ports
//   clk, rstn                       clock, asynchronous active-low reset
//   addr/icache_arb_req/SUC         Icache read request (address, uncached)
//   arb_icache_addrOK/dataOK/dout   Icache acknowledges and line data
//   addr/din/req/wr/SUC/wstrb/size  Dcache request fields
//   arb_dcache_addrOK/dataOK/dout   Dcache acknowledges and line data
//   *_arb_l2cache / arb_l2cache_*   registered L2 request fields, src owner tag
//   l2cache_arb_addrOK/dataOK/dout  L2 acknowledges and line data
//   dbg_state                       current FSM state (0 IDLE, 1 ADDR, 2 DATA)
//
// Configuration macro L1L2_ARB_DPRIO_EN:
//   Defined: Dcache wins every tie (fixed priority).
//   Undefined: ties alternate (round robin).
module l1_l2_req_arbiter #(
  parameter  int L1_offset_width = 2,
  localparam int LW = 32 * (1 << L1_offset_width)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [31:0]   addr_icache_arb,
  input  logic          icache_arb_req,
  input  logic          icache_arb_SUC,
  output logic          arb_icache_addrOK,
  output logic          arb_icache_dataOK,
  output logic [LW-1:0] dout_arb_icache,
  input  logic [31:0]   addr_dcache_arb,
  input  logic [31:0]   din_dcache_arb,
  input  logic          dcache_arb_req,
  input  logic          dcache_arb_wr,
  input  logic          dcache_arb_SUC,
  input  logic [3:0]    dcache_arb_wstrb,
  input  logic [1:0]    dcache_arb_size,
  output logic          arb_dcache_addrOK,
  output logic          arb_dcache_dataOK,
  output logic [LW-1:0] dout_arb_dcache,
  output logic [31:0]   addr_arb_l2cache,
  output logic [31:0]   din_arb_l2cache,
  output logic          arb_l2cache_req,
  output logic          arb_l2cache_wr,
  output logic          arb_l2cache_SUC,
  output logic [3:0]    arb_l2cache_wstrb,
  output logic [1:0]    arb_l2cache_size,
  output logic          arb_l2cache_src,
  input  logic          l2cache_arb_addrOK,
  input  logic          l2cache_arb_dataOK,
  input  logic [LW-1:0] dout_l2cache_arb,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        grant_d;   // 1: Dcache wins the grant in this IDLE cycle
  logic        addr_ack;  // L2 accepted the address this cycle
  logic        done;      // L2 completed the transaction this cycle
  logic [31:0] addr_r, din_r;
  logic        wr_r, suc_r, src_r;
  logic [3:0]  wstrb_r;
  logic [1:0]  size_r;

`ifdef L1L2_ARB_DPRIO_EN
  assign grant_d = dcache_arb_req;
`else
  // last_grant: owner of the most recently completed transaction (1 = Dcache).
  // Resetting to Icache makes the first tie go to Dcache.
  logic last_grant;

  assign grant_d = dcache_arb_req & (~icache_arb_req | ~last_grant);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= 1'b0;
    end else if (done) begin
      last_grant <= src_r;
    end
  end
`endif

  assign addr_ack = (state == ADDR) && l2cache_arb_addrOK;
  assign done     = ((state == DATA) || addr_ack) && l2cache_arb_dataOK;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (icache_arb_req || dcache_arb_req) state_nxt = ADDR;
      ADDR: if (l2cache_arb_addrOK) state_nxt = l2cache_arb_dataOK ? IDLE : DATA;
      DATA: if (l2cache_arb_dataOK) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once at grant, so requester changes after
  // addrOK cannot disturb the L2 port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_r  <= '0;
      din_r   <= '0;
      wr_r    <= 1'b0;
      suc_r   <= 1'b0;
      wstrb_r <= '0;
      size_r  <= '0;
      src_r   <= 1'b0;
    end else if ((state == IDLE) && (icache_arb_req || dcache_arb_req)) begin
      if (grant_d) begin
        addr_r  <= addr_dcache_arb;
        din_r   <= din_dcache_arb;
        wr_r    <= dcache_arb_wr;
        suc_r   <= dcache_arb_SUC;
        wstrb_r <= dcache_arb_wstrb;
        size_r  <= dcache_arb_size;
        src_r   <= 1'b1;
      end else begin
        // Icache refills are always full-word reads.
        addr_r  <= addr_icache_arb;
        din_r   <= '0;
        wr_r    <= 1'b0;
        suc_r   <= icache_arb_SUC;
        wstrb_r <= 4'hF;
        size_r  <= 2'b10;
        src_r   <= 1'b0;
      end
    end
  end

  assign arb_l2cache_req   = (state == ADDR);
  assign addr_arb_l2cache  = addr_r;
  assign din_arb_l2cache   = din_r;
  assign arb_l2cache_wr    = wr_r;
  assign arb_l2cache_SUC   = suc_r;
  assign arb_l2cache_wstrb = wstrb_r;
  assign arb_l2cache_size  = size_r;
  assign arb_l2cache_src   = src_r;

  assign arb_icache_addrOK = addr_ack & ~src_r;
  assign arb_dcache_addrOK = addr_ack & src_r;
  assign arb_icache_dataOK = done & ~src_r;
  assign arb_dcache_dataOK = done & src_r;
  assign dout_arb_icache   = arb_icache_dataOK ? dout_l2cache_arb : '0;
  assign dout_arb_dcache   = arb_dcache_dataOK ? dout_l2cache_arb : '0;
  assign dbg_state         = state;

endmodule
